// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                  |
// | Purpose  : 640x480@60 raster timing with PIX_LAT-clock pixel lookahead.    |
// |            PIX_LAT must lie in 0..4. Optional colour-bar source behind     |
// |            the VGA_TEST_PATTERN_EN macro (adds the test_mode input).       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int PIX_LAT = 1
) (
  input  logic        vga_clk_25,
  input  logic        rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [15:0] pixel_data,
  output logic        data_req,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);

  localparam logic [9:0]  c_h_last = 10'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [9:0]  c_v_last = 10'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [10:0] c_h_sync = 11'(H_SYNC);
  localparam logic [10:0] c_v_sync = 11'(V_SYNC);
  localparam logic [10:0] c_ha     = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] c_h_end  = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] c_va     = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] c_v_end  = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] c_lat    = 11'(PIX_LAT);

  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic [10:0] w_h_look;
  logic        w_h_req_win;
  logic        w_h_de_win;
  logic        w_v_win;
  logic        w_de;
  logic [15:0] w_rgb_src;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_fs;
  logic [15:0] r_rgb;

  always_ff @(posedge vga_clk_25) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // 11-bit views so the lookahead sum and the origin subtraction cannot wrap
  always_comb begin
    w_h_ext     = {1'b0, r_h_cnt};
    w_v_ext     = {1'b0, r_v_cnt};
    w_h_look    = w_h_ext + c_lat;
    w_h_req_win = (w_h_look >= c_ha) && (w_h_look < c_h_end);
    w_h_de_win  = (w_h_ext >= c_ha) && (w_h_ext < c_h_end);
    w_v_win     = (w_v_ext >= c_va) && (w_v_ext < c_v_end);
    w_de        = w_h_de_win && w_v_win;
    data_req    = w_h_req_win && w_v_win;
    pixel_xpos  = data_req ? 10'(w_h_look - c_ha) : 10'd0;
    pixel_ypos  = data_req ? 10'(w_v_ext - c_va) : 10'd0;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  r_bar_idx;
  logic [6:0]  r_bar_sub;
  logic [15:0] w_bar_rgb;

  // Bars are 80 pixels wide; counters sit at zero through blanking
  always_ff @(posedge vga_clk_25) begin
    if (!rst_n || !w_de) begin
      r_bar_idx <= '0;
      r_bar_sub <= '0;
    end else if (r_bar_sub == 7'd79) begin
      r_bar_sub <= '0;
      r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_sub <= r_bar_sub + 7'd1;
    end
  end

  always_comb begin
    w_bar_rgb = 16'h0000;
    case (r_bar_idx)
      3'd0:    w_bar_rgb = 16'hFFFF;
      3'd1:    w_bar_rgb = 16'hFFE0;
      3'd2:    w_bar_rgb = 16'h07FF;
      3'd3:    w_bar_rgb = 16'h07E0;
      3'd4:    w_bar_rgb = 16'hF81F;
      3'd5:    w_bar_rgb = 16'hF800;
      3'd6:    w_bar_rgb = 16'h001F;
      default: w_bar_rgb = 16'h0000;
    endcase
  end

  assign w_rgb_src = test_mode ? w_bar_rgb : pixel_data;
`else
  assign w_rgb_src = pixel_data;
`endif

  always_ff @(posedge vga_clk_25) begin
    if (!rst_n) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_de  <= 1'b0;
      r_rgb <= 16'h0000;
      r_fs  <= 1'b0;
    end else begin
      r_hs  <= (w_h_ext >= c_h_sync);
      r_vs  <= (w_v_ext >= c_v_sync);
      r_de  <= w_de;
      r_rgb <= w_de ? w_rgb_src : 16'h0000;
      r_fs  <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    end
  end

  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_de      = r_de;
  assign vga_rgb     = r_rgb;
  assign frame_start = r_fs;

endmodule
`default_nettype wire
